// File: rtl/mem_instr.sv
//==============================================================================
// Module   : mem_instr
// Desc     : IF-stage instruction memory. Combinational read of a fixed
//            RV32I program image; optional write port under IMEM_LOAD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_instr #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_adr,
    output logic [31:0] o_instr,
    output logic        o_misaligned
`ifdef IMEM_LOAD_EN
    ,
    input  logic        i_we,
    input  logic [31:0] i_wadr,
    input  logic [31:0] i_wdata
`endif
);

    localparam logic [29:0] c_depth = 30'(DEPTH);
    localparam int          c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Default program image, indexed by word address.
    function automatic logic [31:0] f_image(input logic [29:0] idx);
        logic [31:0] w;
        case (idx)
            30'd0:   w = 32'h0050_0093;
            30'd1:   w = 32'h00A0_0113;
            30'd2:   w = 32'h0020_81B3;
            30'd3:   w = 32'h4011_0233;
            30'd4:   w = 32'h0030_2023;
            30'd5:   w = 32'h0000_2283;
            30'd6:   w = 32'h0052_8333;
            30'd7:   w = 32'h0020_F3B3;
            30'd8:   w = 32'h0020_E433;
            30'd9:   w = 32'h0020_8463;
            30'd10:  w = 32'h0010_0493;
            30'd11:  w = 32'h0020_0513;
            30'd12:  w = 32'h0020_A5B3;
            30'd13:  w = 32'h0140_006F;
            30'd14:  w = 32'h0030_0613;
            30'd15:  w = 32'h0040_0693;
            30'd16:  w = 32'h0050_0713;
            30'd24:  w = 32'h0000_0793;
            30'd25:  w = 32'h0000_006F;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    logic w_in_range;
    assign w_in_range   = (i_adr[31:2] < c_depth);
    assign o_misaligned = |i_adr[1:0];

`ifdef IMEM_LOAD_EN
    logic [31:0] r_mem [DEPTH];
    logic        w_wr_in_range;
    logic [1:0]  w_unused_wadr;

    assign w_wr_in_range = (i_wadr[31:2] < c_depth);
    assign w_unused_wadr = i_wadr[1:0];

    // Reset reloads the whole array so a loaded program never survives it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= f_image(30'(i));
            end
        end else if (i_we && w_wr_in_range) begin
            r_mem[i_wadr[c_idx_w+1:2]] <= i_wdata;
        end
    end

    always_comb begin
        o_instr = NOP_WORD;
        if (!i_rst_n) begin
            o_instr = NOP_WORD;
        end else if (w_in_range) begin
            o_instr = r_mem[i_adr[c_idx_w+1:2]];
        end else begin
            o_instr = NOP_WORD;
        end
    end
`else
    logic w_unused_clk;
    assign w_unused_clk = i_clk;

    // Unknown address bits fall through to the NOP branch.
    always_comb begin
        o_instr = NOP_WORD;
        if (!i_rst_n) begin
            o_instr = NOP_WORD;
        end else if (w_in_range) begin
            o_instr = f_image(i_adr[31:2]);
        end else begin
            o_instr = NOP_WORD;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_instr.sv
//==============================================================================
// Module   : tb_mem_instr
// Desc     : Directed scoreboard bench for mem_instr (ROM and IMEM_LOAD_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_instr;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] instr;
    logic        misaligned;
`ifdef IMEM_LOAD_EN
    logic        we;
    logic [31:0] wadr;
    logic [31:0] wdata;
`endif

    typedef struct {
        logic [31:0] adr;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_instr #(.DEPTH(64), .NOP_WORD(32'h0000_0013)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_adr        (adr),
        .o_instr      (instr),
        .o_misaligned (misaligned)
`ifdef IMEM_LOAD_EN
        ,
        .i_we         (we),
        .i_wadr       (wadr),
        .i_wdata      (wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] a, input logic [31:0] ei, input logic em);
        exp_t e;
        e.adr = a; e.instr = ei; e.mis = em;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        n_tests++;
        assert (instr === e.instr) else begin
            n_fail++;
            $error("FAIL instr@%08h observed=%08h expected=%08h", e.adr, instr, e.instr);
        end
        n_tests++;
        assert (misaligned === e.mis) else begin
            n_fail++;
            $error("FAIL misaligned@%08h observed=%0b expected=%0b", e.adr, misaligned, e.mis);
        end
    endtask

    // Inputs change 2 units after a falling edge; outputs sampled 1 unit later.
    task automatic step(input logic [31:0] a, input logic [31:0] ei, input logic em);
        @(negedge clk);
        #2;
        adr = a;
        push(a, ei, em);
        #1;
        check();
    endtask

    initial begin
        rst_n = 1'b0;
        adr   = 32'h0;
`ifdef IMEM_LOAD_EN
        we    = 1'b0;
        wadr  = 32'h0;
        wdata = 32'h0;
`endif
        #3;
        push(32'h0, c_nop, 1'b0);
        check();

        // Release between edges: image visible without a clock.
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        push(32'h0, 32'h0050_0093, 1'b0);
        #1;
        check();

        step(32'h04, 32'h00A0_0113, 1'b0);
        step(32'h08, 32'h0020_81B3, 1'b0);
        step(32'h0C, 32'h4011_0233, 1'b0);
        step(32'h10, 32'h0030_2023, 1'b0);
        step(32'h14, 32'h0000_2283, 1'b0);

        // Asynchronous reset mid-sweep.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        push(32'h14, c_nop, 1'b0);
        #1;
        check();
        adr = 32'h15;
        push(32'h15, c_nop, 1'b1);
        #1;
        check();
        adr = 32'h14;
        rst_n = 1'b1;
        push(32'h14, 32'h0000_2283, 1'b0);
        #1;
        check();

        step(32'h18, 32'h0052_8333, 1'b0);
        step(32'h1C, 32'h0020_F3B3, 1'b0);
        step(32'h20, 32'h0020_E433, 1'b0);
        step(32'h24, 32'h0020_8463, 1'b0);
        step(32'h28, 32'h0010_0493, 1'b0);
        step(32'h2C, 32'h0020_0513, 1'b0);
        step(32'h30, 32'h0020_A5B3, 1'b0);
        step(32'h34, 32'h0140_006F, 1'b0);
        step(32'h38, 32'h0030_0613, 1'b0);
        step(32'h3C, 32'h0040_0693, 1'b0);
        step(32'h40, 32'h0050_0713, 1'b0);
        step(32'h44, c_nop,         1'b0);
        step(32'h50, c_nop,         1'b0);
        step(32'h60, 32'h0000_0793, 1'b0);
        step(32'h64, 32'h0000_006F, 1'b0);
        step(32'h09, 32'h0020_81B3, 1'b1);
        step(32'h66, 32'h0000_006F, 1'b1);
        step(32'hFC, c_nop,         1'b0);
        step(32'h100, c_nop,        1'b0);
        step(32'hFFFF_FFFC, c_nop,  1'b0);

`ifdef IMEM_LOAD_EN
        // Load port: in-range write, dropped out-of-range write, reset restore.
        @(negedge clk);
        we = 1'b1; wadr = 32'h52; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0;
        step(32'h50, 32'hDEAD_BEEF, 1'b0);

        @(negedge clk);
        we = 1'b1; wadr = 32'h200; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        we = 1'b0;
        step(32'h00, 32'h0050_0093, 1'b0);
        step(32'h200, c_nop,        1'b0);

        // Write to the word being read shows up right after the edge.
        @(negedge clk);
        adr = 32'h08;
        we = 1'b1; wadr = 32'h08; wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        we = 1'b0;
        push(32'h08, 32'h1234_5678, 1'b0);
        check();

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step(32'h50, c_nop,         1'b0);
        step(32'h08, 32'h0020_81B3, 1'b0);
`endif

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
